vga_sync_gen: RTL and testbench
===============================

VGA_SYNC_GEN -- requirements
Module: vga_sync_gen

Interface
REQ-001 Parameter H_DISPLAY, 640, visible pixels per line.
REQ-002 Parameter H_FRONT, 16, horizontal front porch in pixels.
REQ-003 Parameter H_SYNC, 96, hsync pulse width in pixels.
REQ-004 Parameter H_BACK, 48, horizontal back porch in pixels.
REQ-005 Parameter V_DISPLAY, 480, visible lines per frame.
REQ-006 Parameter V_FRONT, 10, vertical front porch in lines.
REQ-007 Parameter V_SYNC, 2, vsync pulse width in lines.
REQ-008 Parameter V_BACK, 33, vertical back porch in lines.
REQ-009 Port clk  input  1  100 MHz system clock; the only clock.
REQ-010 Port reset  input  1  synchronous, active-high reset.
REQ-011 Port p_tick  output  1  25 MHz pixel enable, one clk wide.
REQ-012 Port x  output  10  current horizontal pixel count.
REQ-013 Port y  output  10  current vertical line count.
REQ-014 Port video_on  output  1  high while (x,y) lies in the visible area.
REQ-015 Port hsync  output  1  horizontal sync, active low.
REQ-016 Port vsync  output  1  vertical sync, active low.
REQ-017 Port frame_tick  output  1  one-clk pulse at the last pixel of each frame.

Function
REQ-018 The block SHALL use a 2-bit free-running divider; p_tick SHALL be high exactly when the divider equals 3, i.e. 1 clk in 4.
REQ-019 The horizontal counter SHALL advance only on clk edges where p_tick is high and SHALL wrap from H_TOTAL-1 (799) to 0, where H_TOTAL is the sum of the four H parameters.
REQ-020 The vertical counter SHALL advance only on the p_tick edge where the horizontal counter wraps, and SHALL wrap from V_TOTAL-1 (524) to 0.
REQ-021 x and y SHALL be driven directly from the counter registers, with no combinational path from any input.
REQ-022 hsync SHALL be registered and SHALL be low exactly while x is in [H_DISPLAY+H_FRONT, H_DISPLAY+H_FRONT+H_SYNC-1] = [656, 751], aligned to the same clk as x.
REQ-023 vsync SHALL be registered and SHALL be low exactly while y is in [V_DISPLAY+V_FRONT, V_DISPLAY+V_FRONT+V_SYNC-1] = [490, 491], aligned to the same clk as y.
REQ-024 video_on SHALL equal (x < H_DISPLAY) AND (y < V_DISPLAY).
REQ-025 frame_tick SHALL be high for exactly one clk, namely the clk where p_tick=1, x=799 and y=524.
REQ-026 x SHALL never exceed 799, and y SHALL never exceed 524.
REQ-027 Counter widths SHALL be 10 bits, with totals up to 1023 supported without overflow.

Reset
REQ-028 While reset is high at a clk edge, the block SHALL clear the divider, x and y to 0 and drive hsync=1, vsync=1, p_tick=0 and frame_tick=0.
REQ-029 Reset asserted mid-line or mid-frame SHALL take effect on the next clk edge regardless of p_tick.
REQ-030 After reset deasserts, the first p_tick SHALL occur on the 4th clk and the first x increment SHALL occur on that same edge.

Structure
REQ-031 The H/V timing constants and the derived H_TOTAL/V_TOTAL SHALL live in a shared timing package/header, which is also used by the pixel-generation stage.
REQ-032 The pixel-tick divider SHALL be a sub-module named pixel_tick_div with ports clk, reset and tick.
REQ-033 All sequential logic SHALL be clocked by clk alone, with no derived clocks.

Verification
REQ-034 Release reset, then count clks between p_tick pulses -> period of exactly 4 clk; first pulse at clk 4.
REQ-035 Run one full line -> x steps 0..799 then returns to 0; hsync low for exactly 96*4=384 clk beginning when x=656; line period 3200 clk.
REQ-036 Run one full frame -> y steps 0..524; vsync low for exactly 2 lines (6400 clk) beginning at y=490; frame_tick fires once per 1,680,000 clk.
REQ-037 Sample video_on at (639,479), (640,0) and (0,480) -> 1, 0, 0 respectively.
REQ-038 Assert reset for 1 clk at x=700, y=491 -> next clk x=0, y=0, hsync=1, vsync=1, p_tick=0; normal timing then resumes per REQ-030.
REQ-039 Check continuously throughout a 3-frame run -> x<800, y<525, and frame_tick count equals 3.

Source files
------------

// File: rtl/vga_sync_gen_pkg.sv
// Shared VGA timing constants (640x480 @ 60 Hz defaults) and helpers used by the
// sync generator and the pixel-generation stage.
package vga_sync_gen_pkg;
  localparam int CNT_W = 10;

  localparam int DEF_H_DISPLAY = 640;
  localparam int DEF_H_FRONT   = 16;
  localparam int DEF_H_SYNC    = 96;
  localparam int DEF_H_BACK    = 48;
  localparam int DEF_V_DISPLAY = 480;
  localparam int DEF_V_FRONT   = 10;
  localparam int DEF_V_SYNC    = 2;
  localparam int DEF_V_BACK    = 33;

  localparam int DEF_H_TOTAL = DEF_H_DISPLAY + DEF_H_FRONT + DEF_H_SYNC + DEF_H_BACK;
  localparam int DEF_V_TOTAL = DEF_V_DISPLAY + DEF_V_FRONT + DEF_V_SYNC + DEF_V_BACK;

  // Inclusive window test used for the sync pulse regions.
  function automatic logic in_window(input logic [CNT_W-1:0] v,
                                     input logic [CNT_W-1:0] lo,
                                     input logic [CNT_W-1:0] hi);
    return (v >= lo) && (v <= hi);
  endfunction
endpackage

// File: rtl/vga_sync_gen_if.sv
// Video timing bundle produced by vga_sync_gen and consumed by pixel generators.
interface vga_sync_gen_if;
  import vga_sync_gen_pkg::*;

  logic             p_tick;
  logic [CNT_W-1:0] x;
  logic [CNT_W-1:0] y;
  logic             video_on;
  logic             hsync;
  logic             vsync;
  logic             frame_tick;

  modport master (output p_tick, x, y, video_on, hsync, vsync, frame_tick);
  modport slave  (input  p_tick, x, y, video_on, hsync, vsync, frame_tick);
endinterface

// File: rtl/vga_sync_gen_pixel_tick_div.sv
// Free-running divide-by-4 producing a one-clk pixel enable when the count is 3.
module pixel_tick_div (
  input  logic clk,
  input  logic reset,
  output logic tick
);
  logic [1:0] div_q;
  logic [1:0] div_d;

  always_comb begin
    div_d = div_q + 2'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      div_q <= 2'd0;
    end else begin
      div_q <= div_d;
    end
  end

  assign tick = (div_q == 2'd3);
endmodule

// File: rtl/vga_sync_gen.sv
// VGA horizontal/vertical timing generator: pixel counters, registered active-low
// syncs, visible-area flag and an end-of-frame pulse, all in the clk domain.
module vga_sync_gen
  import vga_sync_gen_pkg::*;
#(
  parameter int H_DISPLAY = DEF_H_DISPLAY,
  parameter int H_FRONT   = DEF_H_FRONT,
  parameter int H_SYNC    = DEF_H_SYNC,
  parameter int H_BACK    = DEF_H_BACK,
  parameter int V_DISPLAY = DEF_V_DISPLAY,
  parameter int V_FRONT   = DEF_V_FRONT,
  parameter int V_SYNC    = DEF_V_SYNC,
  parameter int V_BACK    = DEF_V_BACK
) (
  input  logic           clk,
  input  logic           reset,
  vga_sync_gen_if.master bus
);
  localparam int H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;

  localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(V_TOTAL - 1);
  localparam logic [CNT_W-1:0] H_VIS    = CNT_W'(H_DISPLAY);
  localparam logic [CNT_W-1:0] V_VIS    = CNT_W'(V_DISPLAY);
  localparam logic [CNT_W-1:0] HS_START = CNT_W'(H_DISPLAY + H_FRONT);
  localparam logic [CNT_W-1:0] HS_END   = CNT_W'(H_DISPLAY + H_FRONT + H_SYNC - 1);
  localparam logic [CNT_W-1:0] VS_START = CNT_W'(V_DISPLAY + V_FRONT);
  localparam logic [CNT_W-1:0] VS_END   = CNT_W'(V_DISPLAY + V_FRONT + V_SYNC - 1);

  logic             p_tick;
  logic [CNT_W-1:0] x_q, x_d;
  logic [CNT_W-1:0] y_q, y_d;
  logic             hsync_q, hsync_d;
  logic             vsync_q, vsync_d;

  pixel_tick_div u_tick_div (
    .clk   (clk),
    .reset (reset),
    .tick  (p_tick)
  );

  // Syncs are derived from the next counter values so they land on the same edge as x/y.
  always_comb begin
    x_d = x_q;
    y_d = y_q;
    if (p_tick) begin
      if (x_q == H_LAST) begin
        x_d = '0;
        y_d = (y_q == V_LAST) ? '0 : y_q + CNT_W'(1);
      end else begin
        x_d = x_q + CNT_W'(1);
      end
    end
    hsync_d = !in_window(x_d, HS_START, HS_END);
    vsync_d = !in_window(y_d, VS_START, VS_END);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      x_q     <= '0;
      y_q     <= '0;
      hsync_q <= 1'b1;
      vsync_q <= 1'b1;
    end else begin
      x_q     <= x_d;
      y_q     <= y_d;
      hsync_q <= hsync_d;
      vsync_q <= vsync_d;
    end
  end

  assign bus.p_tick     = p_tick;
  assign bus.x          = x_q;
  assign bus.y          = y_q;
  assign bus.hsync      = hsync_q;
  assign bus.vsync      = vsync_q;
  assign bus.video_on   = (x_q < H_VIS) && (y_q < V_VIS);
  assign bus.frame_tick = p_tick && (x_q == H_LAST) && (y_q == V_LAST);
endmodule

// File: tb/tb_vga_sync_gen.sv
// Bench for vga_sync_gen: a small-timing instance for whole-frame runs and a
// default 640x480 instance for full-line checks, against a cycle-count model.
module tb_vga_sync_gen;
  typedef struct packed {
    int hd; int hf; int hs; int hb;
    int vd; int vf; int vs; int vb;
  } timing_t;

  localparam int S_HD = 16, S_HF = 4, S_HS = 6, S_HB = 4;
  localparam int S_VD = 10, S_VF = 2, S_VS = 2, S_VB = 3;
  localparam int S_HT = S_HD + S_HF + S_HS + S_HB;  // 30
  localparam int S_VT = S_VD + S_VF + S_VS + S_VB;  // 17
  localparam timing_t TS = '{S_HD, S_HF, S_HS, S_HB, S_VD, S_VF, S_VS, S_VB};
  localparam timing_t TD = '{640, 16, 96, 48, 480, 10, 2, 33};
  localparam logic [25:0] RST_VEC = {1'b0, 10'd0, 10'd0, 1'b1, 1'b1, 1'b1, 1'b0};

  logic   clk = 1'b0;
  logic   reset = 1'b1;
  longint k = 0;
  int     n_cmp = 0;
  int     n_bad = 0;

  vga_sync_gen_if bus_s ();
  vga_sync_gen_if bus_d ();

  vga_sync_gen #(
    .H_DISPLAY (S_HD), .H_FRONT (S_HF), .H_SYNC (S_HS), .H_BACK (S_HB),
    .V_DISPLAY (S_VD), .V_FRONT (S_VF), .V_SYNC (S_VS), .V_BACK (S_VB)
  ) dut_s (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_s)
  );

  vga_sync_gen dut_d (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_d)
  );

  always #5 clk = ~clk;

  // Clock edges elapsed since the last edge that saw reset high.
  always @(posedge clk) begin
    if (reset) k <= 0;
    else       k <= k + 1;
  end

  logic [25:0] obs_s, obs_d;
  assign obs_s = {bus_s.p_tick, bus_s.x, bus_s.y, bus_s.video_on, bus_s.hsync, bus_s.vsync, bus_s.frame_tick};
  assign obs_d = {bus_d.p_tick, bus_d.x, bus_d.y, bus_d.video_on, bus_d.hsync, bus_d.vsync, bus_d.frame_tick};

  // Pixel number = completed pixel ticks = kk/4; the raster position follows from it.
  function automatic logic [25:0] model(input timing_t t, input longint kk);
    longint p;
    int ht, vt, px, py;
    logic pt, hs, vs, vo, ft;
    ht = t.hd + t.hf + t.hs + t.hb;
    vt = t.vd + t.vf + t.vs + t.vb;
    p  = kk / 4;
    px = int'(p % ht);
    py = int'((p / ht) % vt);
    pt = ((kk % 4) == 3);
    hs = !((px >= t.hd + t.hf) && (px < t.hd + t.hf + t.hs));
    vs = !((py >= t.vd + t.vf) && (py < t.vd + t.vf + t.vs));
    vo = (px < t.hd) && (py < t.vd);
    ft = pt && (px == ht - 1) && (py == vt - 1);
    return {pt, 10'(px), 10'(py), vo, hs, vs, ft};
  endfunction

  task automatic pulse_reset();
    @(negedge clk) reset = 1'b1;
    @(negedge clk) reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_cmp++;
      if (obs_s !== RST_VEC) begin
        n_bad++;
        $display("FAIL reset_small: got %h required %h", obs_s, RST_VEC);
      end
      n_cmp++;
      if (obs_d !== RST_VEC) begin
        n_bad++;
        $display("FAIL reset_default: got %h required %h", obs_d, RST_VEC);
      end
    end
    reset = 1'b0;
  endtask

  task automatic test_tick_period();
    int first = -1, last = -1;
    pulse_reset();
    for (int cyc = 1; cyc <= 41; cyc++) begin
      @(negedge clk);
      if (cyc == 3 || cyc == 4) begin
        n_cmp++;
        if (bus_s.x !== 10'(cyc - 3)) begin
          n_bad++;
          $display("FAIL first_x_incr: cyc %0d x got %0d required %0d", cyc, bus_s.x, cyc - 3);
        end
      end
      if (bus_s.p_tick === 1'b1) begin
        if (first < 0) begin
          first = cyc;
          n_cmp++;
          if (first != 3) begin
            n_bad++;
            $display("FAIL first_tick: got edge %0d required 3", first);
          end
        end else begin
          n_cmp++;
          if (cyc - last != 4) begin
            n_bad++;
            $display("FAIL tick_period: got %0d required 4", cyc - last);
          end
        end
        last = cyc;
      end
    end
    n_cmp++;
    if (first < 0) begin
      n_bad++;
      $display("FAIL tick_seen: got none required a p_tick within 41 clk");
    end
  endtask

  task automatic test_line_default();
    int hs_low = 0, hs_first_x = -1, wrap_k = -1, max_x = 0;
    pulse_reset();
    for (int cyc = 1; cyc <= 3300; cyc++) begin
      @(negedge clk);
      n_cmp++;
      if (obs_d !== model(TD, k)) begin
        n_bad++;
        $display("FAIL line_default: k %0d got %h required %h", k, obs_d, model(TD, k));
      end
      if (bus_d.hsync === 1'b0) begin
        if (hs_first_x < 0) hs_first_x = int'(bus_d.x);
        hs_low++;
      end
      if (int'(bus_d.x) > max_x) max_x = int'(bus_d.x);
      if (wrap_k < 0 && max_x > 0 && bus_d.x === 10'd0) wrap_k = int'(k);
    end
    n_cmp++;
    if (hs_low != 384) begin n_bad++; $display("FAIL hsync_width: got %0d required 384", hs_low); end
    n_cmp++;
    if (hs_first_x != 656) begin n_bad++; $display("FAIL hsync_start: got %0d required 656", hs_first_x); end
    n_cmp++;
    if (wrap_k != 3200) begin n_bad++; $display("FAIL line_period: got %0d required 3200", wrap_k); end
    n_cmp++;
    if (max_x != 799) begin n_bad++; $display("FAIL x_max: got %0d required 799", max_x); end
  endtask

  task automatic test_frames_small();
    int frames = 0, vs_low = 0, vs_first_y = -1, last_ft = -1;
    pulse_reset();
    for (int cyc = 1; cyc <= 3 * S_HT * S_VT * 4; cyc++) begin
      @(negedge clk);
      n_cmp++;
      if (obs_s !== model(TS, k)) begin
        n_bad++;
        $display("FAIL frame_small: k %0d got %h required %h", k, obs_s, model(TS, k));
      end
      n_cmp++;
      if (bus_s.x >= 10'(S_HT) || bus_s.y >= 10'(S_VT)) begin
        n_bad++;
        $display("FAIL xy_range: got x %0d y %0d required below %0d/%0d", bus_s.x, bus_s.y, S_HT, S_VT);
      end
      if (k < S_HT * S_VT * 4 && bus_s.vsync === 1'b0) begin
        if (vs_first_y < 0) vs_first_y = int'(bus_s.y);
        vs_low++;
      end
      if (bus_s.frame_tick === 1'b1) begin
        frames++;
        if (last_ft >= 0) begin
          n_cmp++;
          if (int'(k) - last_ft != S_HT * S_VT * 4) begin
            n_bad++;
            $display("FAIL frame_period: got %0d required %0d", int'(k) - last_ft, S_HT * S_VT * 4);
          end
        end
        last_ft = int'(k);
      end
    end
    n_cmp++;
    if (frames != 3) begin n_bad++; $display("FAIL frame_count: got %0d required 3", frames); end
    n_cmp++;
    if (vs_low != 2 * S_HT * 4) begin n_bad++; $display("FAIL vsync_width: got %0d required %0d", vs_low, 2 * S_HT * 4); end
    n_cmp++;
    if (vs_first_y != S_VD + S_VF) begin n_bad++; $display("FAIL vsync_start: got %0d required %0d", vs_first_y, S_VD + S_VF); end
  endtask

  task automatic test_video_on();
    pulse_reset();
    for (int cyc = 1; cyc <= 2560; cyc++) begin
      @(negedge clk);
      if (k == 4 * (S_HD)) begin
        n_cmp++;
        if ({bus_s.x, bus_s.y, bus_s.video_on} !== {10'(S_HD), 10'd0, 1'b0}) begin
          n_bad++;
          $display("FAIL vid_right_edge: got x %0d y %0d vo %b required %0d 0 0", bus_s.x, bus_s.y, bus_s.video_on, S_HD);
        end
      end
      if (k == 4 * ((S_VD - 1) * S_HT + S_HD - 1)) begin
        n_cmp++;
        if ({bus_s.x, bus_s.y, bus_s.video_on} !== {10'(S_HD - 1), 10'(S_VD - 1), 1'b1}) begin
          n_bad++;
          $display("FAIL vid_last_visible: got x %0d y %0d vo %b required %0d %0d 1", bus_s.x, bus_s.y, bus_s.video_on, S_HD - 1, S_VD - 1);
        end
      end
      if (k == 4 * (S_VD * S_HT)) begin
        n_cmp++;
        if ({bus_s.x, bus_s.y, bus_s.video_on} !== {10'd0, 10'(S_VD), 1'b0}) begin
          n_bad++;
          $display("FAIL vid_bottom_edge: got x %0d y %0d vo %b required 0 %0d 0", bus_s.x, bus_s.y, bus_s.video_on, S_VD);
        end
      end
      if (k == 4 * 639 || k == 4 * 640) begin
        n_cmp++;
        if (bus_d.video_on !== (k == 4 * 639)) begin
          n_bad++;
          $display("FAIL vid_default: x %0d got %b required %b", bus_d.x, bus_d.video_on, (k == 4 * 639));
        end
      end
    end
  endtask

  task automatic test_mid_reset();
    longint tgt;
    tgt = 4 * longint'((S_VD + S_VF + 1) * S_HT + S_HD + S_HF + 2) + longint'($urandom_range(0, 3));
    pulse_reset();
    for (int cyc = 0; cyc < 4000 && k < tgt; cyc++) @(negedge clk);
    n_cmp++;
    if ({bus_s.hsync, bus_s.vsync} !== 2'b00) begin
      n_bad++;
      $display("FAIL pre_reset_sync: k %0d got %b required 00", k, {bus_s.hsync, bus_s.vsync});
    end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    n_cmp++;
    if (obs_s !== RST_VEC) begin
      n_bad++;
      $display("FAIL mid_reset: got %h required %h", obs_s, RST_VEC);
    end
    for (int cyc = 1; cyc <= 12; cyc++) begin
      @(negedge clk);
      n_cmp++;
      if (obs_s !== model(TS, k)) begin
        n_bad++;
        $display("FAIL after_reset: k %0d got %h required %h", k, obs_s, model(TS, k));
      end
    end
  endtask

  task automatic test_random_resets();
    for (int it = 0; it < 6; it++) begin
      int run_len, rst_len;
      run_len = int'($urandom_range(1, 3000));
      rst_len = int'($urandom_range(1, 3));
      for (int cyc = 0; cyc < run_len; cyc++) begin
        @(negedge clk);
        n_cmp++;
        if (obs_s !== model(TS, k) || obs_d !== model(TD, k)) begin
          n_bad++;
          $display("FAIL random_run: k %0d got %h/%h required %h/%h", k, obs_s, obs_d, model(TS, k), model(TD, k));
        end
      end
      reset = 1'b1;
      for (int cyc = 0; cyc < rst_len; cyc++) begin
        @(negedge clk);
        n_cmp++;
        if (obs_s !== RST_VEC || obs_d !== RST_VEC) begin
          n_bad++;
          $display("FAIL random_reset: got %h/%h required %h", obs_s, obs_d, RST_VEC);
        end
      end
      reset = 1'b0;
    end
  endtask

  initial begin
    test_reset();
    test_tick_period();
    test_line_default();
    test_frames_small();
    test_video_on();
    test_mid_reset();
    test_random_resets();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
